// File: rtl/rv_pkg.sv
// Shared register-file types and widths for the writeback path.
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one busy bit per architectural register, x0 never busy.
module rf_scoreboard #(
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  rv_pkg::reg_addr_t set_rd,
  input  logic              clr_en,
  input  rv_pkg::reg_addr_t clr_rd,
  input  rv_pkg::reg_addr_t rs1,
  input  rv_pkg::reg_addr_t rs2,
  output logic              busy_rs1,
  output logic              busy_rs2
);
  import rv_pkg::*;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // Set is applied after clear so a newly issued load to the same register wins.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_rd] = 1'b0;
    if (set_en) busy_next[set_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

  assign busy_rs1 = busy[rs1];
  assign busy_rs2 = busy[rs2];
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: ALU has priority, LSU gets it after MAX_WAIT refusals.
module rf_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  rv_pkg::reg_addr_t alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  rv_pkg::reg_addr_t lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              issue_valid,
  input  rv_pkg::reg_addr_t issue_rd,
  input  rv_pkg::reg_addr_t rs1,
  input  rv_pkg::reg_addr_t rs2,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              rf_we,
  output rv_pkg::reg_addr_t rf_rd,
  output logic [XLEN-1:0]   rf_wdata
);
  import rv_pkg::*;

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              starve;
  logic              alu_grant;
  logic              lsu_grant;

  assign starve    = (wait_cnt >= MAX_WAIT_C);
  assign alu_ready = reset && !(lsu_valid && starve);
  assign lsu_ready = reset && (!alu_valid || starve);
  assign alu_grant = alu_valid && alu_ready;
  assign lsu_grant = lsu_valid && lsu_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (lsu_grant || !lsu_valid) begin
      wait_cnt <= '0;
    end else if (wait_cnt < MAX_WAIT_C) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // rd==0 still completes the handshake but never pulses the write enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else if (alu_grant) begin
      rf_we    <= (alu_rd != '0);
      rf_rd    <= alu_rd;
      rf_wdata <= alu_data;
    end else if (lsu_grant) begin
      rf_we    <= (lsu_rd != '0);
      rf_rd    <= lsu_rd;
      rf_wdata <= lsu_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (issue_valid && (issue_rd != '0)),
    .set_rd   (issue_rd),
    .clr_en   (lsu_grant),
    .clr_rd   (lsu_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2)
  );
endmodule
